num_rom_arbiter: RTL and testbench
==================================

Name: num_rom_arbiter

Overview:
- Shares one single-port glyph ROM (num_rom, digit/character bitmaps) between N_REQ on-screen text-overlay requesters, e.g. frequency, Vpp, timebase and V/div readouts.
- Round-robin grant with registered ROM address and a tag pipeline that matches ROM read latency.
- Returns each read word with the ID of the requester that issued it.
- Sits between the overlay renderers and the ROM IP instance in the display path.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADDR_W, 10, ROM address width.
- DATA_W, 32, ROM data width.
- ROM_LAT, 1, ROM read latency in cycles from sampled address to data: 1 = no output register, 2 = output register enabled.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- arb_en  in  1  1 = arbitration enabled; 0 = no new grants.
- req  in  N_REQ  per-requester read request, level.
- req_addr  in  N_REQ*ADDR_W  packed addresses; slice i belongs to req[i].
- gnt  out  N_REQ  one-hot grant, combinational, same cycle as the winning request.
- rom_addr  out  ADDR_W  registered address to ROM.
- rom_rd_data  in  DATA_W  ROM read data.
- rsp_valid  out  1  response word valid, one-cycle pulse per grant.
- rsp_id  out  clog2(N_REQ)  requester index of the response.
- rsp_data  out  DATA_W  response word, equal to rom_rd_data in the rsp_valid cycle.
- busy  out  1  1 while any grant is in flight.

Behaviour:
- Reset (async assert, sync release by clk edge): gnt=0, rom_addr=0, rsp_valid=0, rsp_id=0, busy=0, RR pointer=0, all tag stages invalid.
- Request handshake:
  - Requester holds req[i] and its address stable until it sees gnt[i] high in the same cycle.
  - At most one grant per cycle.
  - Requester drops req or presents the next address from the following cycle.
- Arbitration:
  - Only when arb_en=1 and any req is set.
  - Winner is the first set req scanning from the RR pointer upward, mod N_REQ.
  - On the grant edge: pointer <= winner+1 mod N_REQ; rom_addr <= req_addr[winner].
  - No grant: pointer and rom_addr hold.
- Latency:
  - Grant in cycle t -> rom_addr valid in t+1 -> rsp_valid in cycle t+1+ROM_LAT.
  - Sustained throughput is one response per cycle.
- Tag pipeline:
  - Depth 1+ROM_LAT, each stage holding {valid, id}.
  - Shifts every cycle; the last stage drives rsp_valid and rsp_id.
  - rsp_data is rom_rd_data passed through combinationally and is meaningful only while rsp_valid=1.
- busy = OR of the tag-stage valids.
- arb_en deassert mid-operation: in-flight reads still complete, no new gnt; pointer held.
- Responses cannot be back-pressured. Consumers must accept rsp_valid in the cycle it occurs.
- Fairness: a continuously asserted req[i] is granted within N_REQ cycles of arb_en=1.
- Reset mid-operation: in-flight responses are discarded and no rsp_valid is issued after reset for pre-reset grants.
- Out-of-range requester bits do not exist. req_addr slices for idle requesters are don't-care.

Optional Feature:
- Macro NUM_ROM_ARB_PRIO0_EN.
- Defined: requester 0 has strict priority. If req[0]=1 it wins regardless of the pointer, and the pointer is not updated. Other requesters are round-robin among themselves when req[0]=0. Used for the live cursor readout.
- Undefined: pure round-robin across all N_REQ as above. Fairness bound holds only without the macro.

Decomposition:
- Package num_rom_arb_pkg:
  - ID_W = clog2(N_REQ) helper function.
  - Tag struct {valid, id}.
  - Localparam MAX_REQ = 8.
- Sub-module num_rom_rr_pick:
  - Combinational rotate-priority picker.
  - Inputs: req vector and pointer. Outputs: one-hot grant and encoded index.
  - Instantiated once. Pipeline and pointer registers live in the top.

Test Plan:
- Reset then single request: ROM_LAT=1, req=4'b0100, addr=0x123. Expect gnt=4'b0100 in t, rom_addr=0x123 in t+1, rsp_valid=1 with rsp_id=2 in t+2, busy high t+1..t+2.
- All requesting: req=4'b1111 held 8 cycles. Expect grants in order 0,1,2,3,0,1,2,3, then rsp_id in the same order with 1 response/cycle and no gaps. Without the macro, each id gets exactly 2 grants.
- ROM_LAT=2: back-to-back grants for ids 1 then 3. Expect rsp_valid at t+3 and t+4 with ids 1,3 and data from the ROM model for each address.
- arb_en drop: deassert arb_en the cycle after a grant. Expect no further gnt, the in-flight response still delivered, and busy returning to 0. Re-enable resumes from the held pointer.
- Async reset mid-flight: assert rst_n low between grant and response. Expect rsp_valid stays 0 after release and pointer=0.
- With NUM_ROM_ARB_PRIO0_EN: req=4'b1011, req[0] held 3 cycles then dropped. Expect gnt=0001 x3, then id1, then id3.

Source files
------------

// File: rtl/num_rom_arb_pkg.sv
// Shared sizing helpers and the response tag type for the num_rom glyph ROM arbiter.
package num_rom_arb_pkg;

    localparam int MAX_REQ = 8;

    // Requester index width; never narrower than one bit.
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int TAG_ID_W = id_w(MAX_REQ);

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/num_rom_rr_pick.sv
// Combinational rotate-priority picker: the first set request at or above ptr wins, wrapping mod N_REQ.
module num_rom_rr_pick
    import num_rom_arb_pkg::*;
#(
    parameter int  N_REQ = 4,
    localparam int ID_W  = id_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] slot;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        sum  = '0;
        slot = '0;
        for (int k = 0; k < N_REQ; k++) begin
            // One extra bit keeps ptr+k from wrapping before the explicit mod.
            sum = {1'b0, ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(N_REQ)) begin
                sum = sum - (ID_W+1)'(N_REQ);
            end
            slot = sum[ID_W-1:0];
            if (!any && req[slot]) begin
                any       = 1'b1;
                gnt[slot] = 1'b1;
                idx       = slot;
            end
        end
    end

endmodule

// File: rtl/num_rom_arbiter.sv
// Round-robin arbiter sharing one single-port glyph ROM among N_REQ overlay requesters, with a tag
// pipeline matched to ROM latency. Optional macro NUM_ROM_ARB_PRIO0_EN gives requester 0 strict priority.
module num_rom_arbiter
    import num_rom_arb_pkg::*;
#(
    parameter int  N_REQ   = 4,
    parameter int  ADDR_W  = 10,
    parameter int  DATA_W  = 32,
    parameter int  ROM_LAT = 1,
    localparam int ID_W    = id_w(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    arb_en,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [DATA_W-1:0]       rom_rd_data,
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    busy
);

    // Handshake: req[i] is a level request whose address is held until gnt[i] is seen high in the
    // same cycle; that cycle is the transfer. rsp_valid is a one-cycle pulse with no ready -- the
    // consumer must take it when it occurs.

    localparam int DEPTH = 1 + ROM_LAT;

    logic [ID_W-1:0]    ptr;
    logic [N_REQ-1:0]   pick_req;
    logic [N_REQ-1:0]   pick_gnt;
    logic [ID_W-1:0]    pick_idx;
    logic               pick_any;

    logic [N_REQ-1:0]   sel_gnt;
    logic [ID_W-1:0]    win_idx;
    logic               sel_any;
    logic               upd_ptr;
    logic               grant_any;
    logic [ID_W-1:0]    next_ptr;
    logic [ADDR_W-1:0]  win_addr;

    tag_t [DEPTH-1:0]   tags;

    num_rom_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req (pick_req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

`ifdef NUM_ROM_ARB_PRIO0_EN
    // Requester 0 bypasses the rotation and leaves the pointer alone; the rest rotate among themselves.
    assign pick_req = {req[N_REQ-1:1], 1'b0};

    always_comb begin
        if (req[0]) begin
            sel_gnt = {{(N_REQ-1){1'b0}}, 1'b1};
            win_idx = '0;
            sel_any = 1'b1;
            upd_ptr = 1'b0;
        end else begin
            sel_gnt = pick_gnt;
            win_idx = pick_idx;
            sel_any = pick_any;
            upd_ptr = pick_any;
        end
    end
`else
    assign pick_req = req;
    assign sel_gnt  = pick_gnt;
    assign win_idx  = pick_idx;
    assign sel_any  = pick_any;
    assign upd_ptr  = pick_any;
`endif

    // Reset also masks the combinational grant so nothing is handed out while the arbiter is held.
    assign grant_any = arb_en & rst_n & sel_any;
    assign gnt       = grant_any ? sel_gnt : '0;
    assign next_ptr  = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

    always_comb begin
        win_addr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == ID_W'(i)) begin
                win_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            rom_addr <= '0;
        end else if (grant_any) begin
            rom_addr <= win_addr;
            if (upd_ptr) begin
                ptr <= next_ptr;
            end
        end
    end

    // Tag stage 0 lines up with rom_addr; the last stage lines up with rom_rd_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tags <= '0;
        end else begin
            tags[0] <= tag_t'{valid: grant_any, id: TAG_ID_W'(win_idx)};
            for (int k = 1; k < DEPTH; k++) begin
                tags[k] <= tags[k-1];
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            busy = busy | tags[k].valid;
        end
    end

    assign rsp_valid = tags[DEPTH-1].valid;
    assign rsp_id    = ID_W'(tags[DEPTH-1].id);
    assign rsp_data  = rom_rd_data;

endmodule

// File: tb/tb_num_rom_arbiter.sv
// Directed bench for num_rom_arbiter: one instance at ROM_LAT=1 and one at ROM_LAT=2, each with a ROM model.
module tb_num_rom_arbiter;

    logic clk;
    logic rst_n;

    logic        en1, en2;
    logic [3:0]  req1, req2;
    logic [39:0] addr1, addr2;
    logic [3:0]  gnt1, gnt2;
    logic [9:0]  rom_addr1, rom_addr2;
    logic [31:0] rom_data1, rom_data2, rom_stage2;
    logic        rsp_valid1, rsp_valid2;
    logic [1:0]  rsp_id1, rsp_id2;
    logic [31:0] rsp_data1, rsp_data2;
    logic        busy1, busy2;

    int tests_run;
    int tests_failed;

    logic [9:0] a_tab [4];
    logic [1:0] exp_q [$];

    num_rom_arbiter #(.N_REQ(4), .ADDR_W(10), .DATA_W(32), .ROM_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .arb_en(en1), .req(req1), .req_addr(addr1), .gnt(gnt1),
        .rom_addr(rom_addr1), .rom_rd_data(rom_data1), .rsp_valid(rsp_valid1), .rsp_id(rsp_id1),
        .rsp_data(rsp_data1), .busy(busy1)
    );

    num_rom_arbiter #(.N_REQ(4), .ADDR_W(10), .DATA_W(32), .ROM_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .arb_en(en2), .req(req2), .req_addr(addr2), .gnt(gnt2),
        .rom_addr(rom_addr2), .rom_rd_data(rom_data2), .rsp_valid(rsp_valid2), .rsp_id(rsp_id2),
        .rsp_data(rsp_data2), .busy(busy2)
    );

    function automatic logic [31:0] rom_f(input logic [9:0] a);
        return {6'h2A, a, 6'h15, ~a};
    endfunction

    // Clock / reset and ROM models
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_data1 <= rom_f(rom_addr1);
    always @(posedge clk) begin
        rom_stage2 <= rom_f(rom_addr2);
        rom_data2  <= rom_stage2;
    end

    task automatic do_reset();
        rst_n = 1'b0;
        en1 = 1'b0; en2 = 1'b0; req1 = '0; req2 = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en1 = 1'b1; req1 = 4'b1111;
        @(negedge clk); #1;
        tests_run++; if (gnt1 !== 4'b0000) begin tests_failed++; $display("FAIL reset_gnt: got %b exp 0000", gnt1); end
        tests_run++; if (rom_addr1 !== 10'h000) begin tests_failed++; $display("FAIL reset_rom_addr: got %h exp 000", rom_addr1); end
        tests_run++; if (rsp_valid1 !== 1'b0 || rsp_id1 !== 2'd0) begin tests_failed++; $display("FAIL reset_rsp: got v=%b id=%0d exp v=0 id=0", rsp_valid1, rsp_id1); end
        tests_run++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b/%b exp 0/0", busy1, busy2); end
        en1 = 1'b0; req1 = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk); en1 = 1'b1; req1 = 4'b0100; #1;
        tests_run++; if (gnt1 !== 4'b0100) begin tests_failed++; $display("FAIL single_gnt: got %b exp 0100", gnt1); end
        tests_run++; if (busy1 !== 1'b0) begin tests_failed++; $display("FAIL single_busy_t: got %b exp 0", busy1); end
        @(negedge clk); req1 = 4'b0000; #1;
        tests_run++; if (rom_addr1 !== 10'h123) begin tests_failed++; $display("FAIL single_rom_addr: got %h exp 123", rom_addr1); end
        tests_run++; if (busy1 !== 1'b1 || rsp_valid1 !== 1'b0) begin tests_failed++; $display("FAIL single_t1: got busy=%b v=%b exp busy=1 v=0", busy1, rsp_valid1); end
        @(negedge clk); #1;
        tests_run++; if (rsp_valid1 !== 1'b1 || rsp_id1 !== 2'd2) begin tests_failed++; $display("FAIL single_rsp: got v=%b id=%0d exp v=1 id=2", rsp_valid1, rsp_id1); end
        tests_run++; if (rsp_data1 !== rom_f(10'h123) || busy1 !== 1'b1) begin tests_failed++; $display("FAIL single_data: got %h busy=%b exp %h busy=1", rsp_data1, busy1, rom_f(10'h123)); end
        @(negedge clk); #1;
        tests_run++; if (rsp_valid1 !== 1'b0 || busy1 !== 1'b0) begin tests_failed++; $display("FAIL single_done: got v=%b busy=%b exp 0/0", rsp_valid1, busy1); end
    endtask

    task automatic test_all_req();
        int cnt [4];
        logic [3:0] e_gnt;
        logic [1:0] e_id;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        exp_q.delete();
        do_reset();
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            en1 = 1'b1;
            req1 = (c < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (c < 8) begin
`ifdef NUM_ROM_ARB_PRIO0_EN
                e_id = 2'd0;
`else
                e_id = 2'(c % 4);
`endif
                e_gnt = 4'b0001 << e_id;
                tests_run++; if (gnt1 !== e_gnt) begin tests_failed++; $display("FAIL all_gnt c=%0d: got %b exp %b", c, gnt1, e_gnt); end
                for (int i = 0; i < 4; i++) if (gnt1[i]) cnt[i]++;
                exp_q.push_back(e_id);
            end
            if (c >= 2 && c < 10) begin
                e_id = exp_q.pop_front();
                tests_run++; if (rsp_valid1 !== 1'b1 || rsp_id1 !== e_id) begin tests_failed++; $display("FAIL all_rsp c=%0d: got v=%b id=%0d exp v=1 id=%0d", c, rsp_valid1, rsp_id1, e_id); end
                tests_run++; if (rsp_data1 !== rom_f(a_tab[e_id])) begin tests_failed++; $display("FAIL all_data c=%0d: got %h exp %h", c, rsp_data1, rom_f(a_tab[e_id])); end
            end
            if (c == 10) begin
                tests_run++; if (rsp_valid1 !== 1'b0 || busy1 !== 1'b0) begin tests_failed++; $display("FAIL all_idle: got v=%b busy=%b exp 0/0", rsp_valid1, busy1); end
            end
        end
`ifndef NUM_ROM_ARB_PRIO0_EN
        for (int i = 0; i < 4; i++) begin
            tests_run++; if (cnt[i] != 2) begin tests_failed++; $display("FAIL all_count id=%0d: got %0d exp 2", i, cnt[i]); end
        end
`endif
        en1 = 1'b0;
    endtask

    task automatic test_back_to_back_lat2();
        do_reset();
        @(negedge clk); en2 = 1'b1; req2 = 4'b1010; #1;
        tests_run++; if (gnt2 !== 4'b0010) begin tests_failed++; $display("FAIL b2b_gnt0: got %b exp 0010", gnt2); end
        @(negedge clk); req2 = 4'b1000; #1;
        tests_run++; if (gnt2 !== 4'b1000) begin tests_failed++; $display("FAIL b2b_gnt1: got %b exp 1000", gnt2); end
        @(negedge clk); req2 = 4'b0000; #1;
        tests_run++; if (rsp_valid2 !== 1'b0 || busy2 !== 1'b1) begin tests_failed++; $display("FAIL b2b_t2: got v=%b busy=%b exp v=0 busy=1", rsp_valid2, busy2); end
        @(negedge clk); #1;
        tests_run++; if (rsp_valid2 !== 1'b1 || rsp_id2 !== 2'd1 || rsp_data2 !== rom_f(a_tab[1])) begin tests_failed++; $display("FAIL b2b_rsp1: got v=%b id=%0d d=%h exp v=1 id=1 d=%h", rsp_valid2, rsp_id2, rsp_data2, rom_f(a_tab[1])); end
        @(negedge clk); #1;
        tests_run++; if (rsp_valid2 !== 1'b1 || rsp_id2 !== 2'd3 || rsp_data2 !== rom_f(a_tab[3])) begin tests_failed++; $display("FAIL b2b_rsp3: got v=%b id=%0d d=%h exp v=1 id=3 d=%h", rsp_valid2, rsp_id2, rsp_data2, rom_f(a_tab[3])); end
        @(negedge clk); #1;
        tests_run++; if (rsp_valid2 !== 1'b0 || busy2 !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle: got v=%b busy=%b exp 0/0", rsp_valid2, busy2); end
        en2 = 1'b0;
    endtask

    task automatic test_arb_en_drop();
        do_reset();
        @(negedge clk); en1 = 1'b1; req1 = 4'b0010; #1;
        tests_run++; if (gnt1 !== 4'b0010) begin tests_failed++; $display("FAIL en_gnt: got %b exp 0010", gnt1); end
        @(negedge clk); en1 = 1'b0; req1 = 4'b1111; #1;
        tests_run++; if (gnt1 !== 4'b0000 || busy1 !== 1'b1) begin tests_failed++; $display("FAIL en_off_t1: got gnt=%b busy=%b exp 0000/1", gnt1, busy1); end
        @(negedge clk); #1;
        tests_run++; if (gnt1 !== 4'b0000 || rsp_valid1 !== 1'b1 || rsp_id1 !== 2'd1) begin tests_failed++; $display("FAIL en_off_rsp: got gnt=%b v=%b id=%0d exp 0000/1/1", gnt1, rsp_valid1, rsp_id1); end
        @(negedge clk); #1;
        tests_run++; if (gnt1 !== 4'b0000 || busy1 !== 1'b0 || rsp_valid1 !== 1'b0) begin tests_failed++; $display("FAIL en_off_idle: got gnt=%b busy=%b v=%b exp 0000/0/0", gnt1, busy1, rsp_valid1); end
        @(negedge clk); en1 = 1'b1; #1;
`ifdef NUM_ROM_ARB_PRIO0_EN
        tests_run++; if (gnt1 !== 4'b0001) begin tests_failed++; $display("FAIL en_resume: got %b exp 0001", gnt1); end
`else
        tests_run++; if (gnt1 !== 4'b0100) begin tests_failed++; $display("FAIL en_resume: got %b exp 0100", gnt1); end
`endif
        @(negedge clk); en1 = 1'b0; req1 = '0;
    endtask

    task automatic test_reset_mid_flight();
        do_reset();
        @(negedge clk); en1 = 1'b1; req1 = 4'b0010; #1;
        tests_run++; if (gnt1 !== 4'b0010) begin tests_failed++; $display("FAIL midrst_gnt: got %b exp 0010", gnt1); end
        @(negedge clk); req1 = 4'b0000; #1;
        rst_n = 1'b0; #1;
        tests_run++; if (busy1 !== 1'b0 || rsp_valid1 !== 1'b0) begin tests_failed++; $display("FAIL midrst_async: got busy=%b v=%b exp 0/0", busy1, rsp_valid1); end
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            tests_run++; if (rsp_valid1 !== 1'b0) begin tests_failed++; $display("FAIL midrst_rsp c=%0d: got %b exp 0", c, rsp_valid1); end
        end
        @(negedge clk); req1 = 4'b0110; #1;
        tests_run++; if (gnt1 !== 4'b0010) begin tests_failed++; $display("FAIL midrst_ptr: got %b exp 0010", gnt1); end
        @(negedge clk); en1 = 1'b0; req1 = '0;
    endtask

    task automatic test_prio0();
        logic [3:0] req_tab [5];
        logic [3:0] exp_tab [5];
        req_tab = '{4'b1011, 4'b1011, 4'b1011, 4'b1010, 4'b1000};
`ifdef NUM_ROM_ARB_PRIO0_EN
        exp_tab = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b1000};
`else
        exp_tab = '{4'b0001, 4'b0010, 4'b1000, 4'b0010, 4'b1000};
`endif
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); en1 = 1'b1; req1 = req_tab[c]; #1;
            tests_run++; if (gnt1 !== exp_tab[c]) begin tests_failed++; $display("FAIL prio_gnt c=%0d: got %b exp %b", c, gnt1, exp_tab[c]); end
        end
        @(negedge clk); en1 = 1'b0; req1 = '0;
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        a_tab = '{10'h05A, 10'h0F0, 10'h123, 10'h3A5};
        for (int i = 0; i < 4; i++) begin
            addr1[i*10 +: 10] = a_tab[i];
            addr2[i*10 +: 10] = a_tab[i];
        end
        en1 = 1'b0; en2 = 1'b0; req1 = '0; req2 = '0;
        test_reset();
        test_single();
        test_all_req();
        test_back_to_back_lat2();
        test_arb_en_drop();
        test_reset_mid_flight();
        test_prio0();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
